// File: rtl/btb_update_sched_pkg.sv
// Shared types for the BTB update path: the update record, scheduler states and
// small predicates used by the scheduler and its FIFO.
`ifndef BTB_ENTRIES
`define BTB_ENTRIES 32
`endif

package btb_update_sched_pkg;

    localparam int unsigned BT_ADDR_W = 32;

    typedef struct packed {
        logic [BT_ADDR_W-1:0] src;
        logic [BT_ADDR_W-1:0] dst;
        logic                 clean;
        logic                 multiple;
        logic                 valid;
    } BTUpdate;

    typedef enum logic [1:0] {
        BTS_INIT = 2'd0,
        BTS_RUN  = 2'd1,
        BTS_GAP  = 2'd2
    } BTSchedState_t;

    // Two updates target the same BTB slot in the same mode, so the later one wins.
    function automatic logic bt_coalesce_match(input BTUpdate a, input BTUpdate b);
        return (a.src == b.src) && (a.clean == b.clean);
    endfunction

    // The BTB needs a spare cycle to commit the deferred multiple bit.
    function automatic logic bt_opens_gap(input BTUpdate u);
        return u.valid && !u.clean && u.multiple;
    endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// DEPTH-entry FIFO of BTB updates: two ordered push ports, one pop port,
// in-place overwrite of the tail on a matching src/clean, and flush.
module btb_update_fifo
    import btb_update_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push0,
    input  BTUpdate               data0,
    input  logic                  push1,
    input  BTUpdate               data1,
    input  logic                  pop,
    output BTUpdate               head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    BTUpdate         mem_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;

    logic            pop_s;
    logic            tail_ok_s;
    logic            co0_s;
    logic            co1_s;
    logic            adv0_s;
    logic            adv1_s;
    logic [PW-1:0]   wr_base_s;
    logic [PW-1:0]   tail_idx_s;
    logic [PW-1:0]   idx0_s;
    logic [PW-1:0]   idx1_s;
    BTUpdate         tail_s;

    // Write slot selection: coalesce into the tail unless that tail leaves this cycle.
    always_comb begin
        pop_s      = pop && !flush && (count_r != {CW{1'b0}});
        wr_base_s  = flush ? {PW{1'b0}} : wr_ptr_r;
        tail_idx_s = wr_ptr_r - PW'(1'b1);
        tail_s     = mem_r[tail_idx_s];
        tail_ok_s  = !flush && (count_r != {CW{1'b0}}) &&
                     !(pop_s && (count_r == CW'(1'b1)));

        co0_s  = push0 && tail_ok_s && bt_coalesce_match(data0, tail_s);
        adv0_s = push0 && !co0_s;
        idx0_s = co0_s ? tail_idx_s : wr_base_s;

        // The second push sees the first push's entry as its tail.
        if (push0) begin
            co1_s  = push1 && bt_coalesce_match(data1, data0);
            idx1_s = co1_s ? idx0_s : (wr_base_s + PW'(adv0_s));
        end else begin
            co1_s  = push1 && tail_ok_s && bt_coalesce_match(data1, tail_s);
            idx1_s = co1_s ? tail_idx_s : wr_base_s;
        end
        adv1_s = push1 && !co1_s;
    end

    // Storage; push1 lands after push0 so a same-slot overwrite keeps the newer entry.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem_r[idx0_s] <= data0;
        end
        if (push1) begin
            mem_r[idx1_s] <= data1;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            rd_ptr_r <= flush ? {PW{1'b0}} : (rd_ptr_r + PW'(pop_s));
            wr_ptr_r <= wr_base_s + PW'(adv0_s) + PW'(adv1_s);
            count_r  <= (flush ? {CW{1'b0}} : count_r) - CW'(pop_s) + CW'(adv0_s) + CW'(adv1_s);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/btb_update_sched.sv
// Schedules branch-resolution and decoder updates onto the BTB's single update
// port, holding off during the BTB clearing sweep and after multiple updates.
module btb_update_sched
    import btb_update_sched_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int INIT_CYCLES = `BTB_ENTRIES
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    IN_flush,
    input  BTUpdate IN_brUpd,
    output logic    OUT_brReady,
    input  BTUpdate IN_decUpd,
    output logic    OUT_decReady,
    output BTUpdate OUT_btUpdate,
    output logic    OUT_busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = $clog2(INIT_CYCLES + 1);

    BTSchedState_t   state_r;
    logic [NW-1:0]   init_cnt_r;
    BTUpdate         out_r;

    logic [CW-1:0]   count_s;
    logic [CW-1:0]   free_s;
    logic [CW-1:0]   dec_need_s;
    BTUpdate         head_s;
    BTUpdate         issue_s;
    logic            active_s;
    logic            run_s;
    logic            empty_eff_s;
    logic            br_acc_s;
    logic            dec_acc_s;
    logic            pop_s;
    logic            byp_br_s;
    logic            byp_dec_s;
    logic            push0_s;
    logic            push1_s;

    // Acceptance, bypass and issue selection, all from pre-pop occupancy.
    always_comb begin
        active_s     = (state_r != BTS_INIT);
        run_s        = (state_r == BTS_RUN);
        free_s       = CW'(DEPTH) - count_s;
        dec_need_s   = CW'(1'b1) + CW'(IN_brUpd.valid);
        OUT_brReady  = active_s && (free_s >= CW'(1'b1));
        OUT_decReady = active_s && (free_s >= dec_need_s);

        br_acc_s    = IN_brUpd.valid && OUT_brReady;
        dec_acc_s   = IN_decUpd.valid && OUT_decReady && !IN_flush;
        empty_eff_s = IN_flush || (count_s == {CW{1'b0}});

        // A flushed head is dropped, so the flush cycle behaves like an empty FIFO.
        pop_s     = run_s && !empty_eff_s;
        byp_br_s  = run_s && empty_eff_s && br_acc_s;
        byp_dec_s = run_s && empty_eff_s && !br_acc_s && dec_acc_s;
        push0_s   = br_acc_s && !byp_br_s;
        push1_s   = dec_acc_s && !byp_dec_s;

        if (pop_s) begin
            issue_s = head_s;
        end else if (byp_br_s) begin
            issue_s = IN_brUpd;
        end else if (byp_dec_s) begin
            issue_s = IN_decUpd;
        end else begin
            issue_s = '0;
        end
        issue_s.valid = pop_s || byp_br_s || byp_dec_s;
    end

    btb_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (IN_flush),
        .push0 (push0_s),
        .data0 (IN_brUpd),
        .push1 (push1_s),
        .data1 (IN_decUpd),
        .pop   (pop_s),
        .head  (head_s),
        .count (count_s)
    );

    // Scheduler state machine and the registered BTB update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= BTS_INIT;
            init_cnt_r <= {NW{1'b0}};
            out_r      <= '0;
        end else begin
            case (state_r)
                BTS_INIT: begin
                    out_r <= '0;
                    if (init_cnt_r == NW'(INIT_CYCLES - 1)) begin
                        state_r <= BTS_RUN;
                    end else begin
                        init_cnt_r <= init_cnt_r + NW'(1'b1);
                    end
                end
                BTS_RUN: begin
                    out_r <= issue_s;
                    if (bt_opens_gap(issue_s)) begin
                        state_r <= BTS_GAP;
                    end else begin
                        state_r <= BTS_RUN;
                    end
                end
                BTS_GAP: begin
                    out_r   <= '0;
                    state_r <= BTS_RUN;
                end
                default: begin
                    out_r      <= '0;
                    state_r    <= BTS_INIT;
                    init_cnt_r <= {NW{1'b0}};
                end
            endcase
        end
    end

    assign OUT_btUpdate = out_r;
    assign OUT_busy     = (state_r == BTS_INIT) || (count_s != {CW{1'b0}}) || out_r.valid;

endmodule
